execute_stage_md: RTL
=====================

Name: execute_stage_md

Overview:
- Parametrised next-generation RV32IM execute stage.
- Adds a multi-cycle iterative multiply/divide unit (M extension) alongside the single-cycle ALU, with a stall handshake to the hazard unit.
- Forwarding selects come from an external hazard unit; the stage has an explicit flush.
- Sits between the decode pipeline register and the memory stage. It owns the E->M pipeline register and feeds PCTargetE/PCSrcE back to fetch.

Parameters:
DATA_WIDTH, 32, datapath width (even, >=8)
ADDR_WIDTH, 5, register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
RegWriteE  in  1  register write enable
ResultSrcE  in  2  result select
MemWriteE  in  1  memory write enable
MemoryOpE  in  3  memory access size/sign
JumpE  in  2  00 none, 01 JAL, 10 JALR
BranchE  in  3  branch funct3; valid only with BranchEnE
BranchEnE  in  1  conditional branch present
ALUControlE  in  4  ALU op
ALUSrcE  in  1  0 = RD2, 1 = ImmExtE
UpperOpE  in  2  SrcA select: 0 = RD1, 1 = zero, 2 = PCE
MdEnE  in  1  instruction is M-extension
MdOpE  in  3  M funct3
RD1E, RD2E, PCE, ImmExtE, PCPlus4E  in  DATA_WIDTH  decode-stage operands
RdE  in  ADDR_WIDTH  destination register
ForwardAE, ForwardBE  in  2  0 = RD, 1 = ResultW, 2 = ALUResultM
ResultW  in  DATA_WIDTH  writeback forward value
FlushE  in  1  kill instruction in E
StallMdE  out  1  stall request to hazard unit
RegWriteM, ResultSrcM, MemWriteM, MemoryOpM, ALUResultM, WriteDataM, RdM, PCPlus4M  out  matching widths  memory-stage register outputs
PCTargetE  out  DATA_WIDTH  branch/jump target, combinational
PCSrcE  out  1  redirect taken, combinational

Behaviour:
- Reset:
  - All M-register outputs are 0.
  - MD FSM goes to IDLE; StallMdE = 0.
- Forwarding: SrcA/RD2 forwarding muxes use ForwardAE/BE; code 3 behaves as 0.
- WriteDataM: captured from the forwarded RD2, not raw RD2E.
- ALUControl encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA (shift amount = SrcB[log2(DATA_WIDTH)-1:0])
  - 8 SLT, 9 SLTU, others -> 0
- Branches:
  - BranchE funct3 values: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU. Compare uses the forwarded RD1/RD2 directly.
  - PCSrcE = (BranchEnE & cond) | (JumpE != 0), gated by !FlushE.
  - PCTargetE = (JumpE == 10 ? fwdRD1 : PCE) + ImmExtE. For JALR, bit 0 is cleared.
- MD FSM states: IDLE, BUSY, DONE. N = DATA_WIDTH.
  - IDLE: if MdEnE & !FlushE, latch operands and go to BUSY with counter = N-1.
    - Operands latched: forwarded SrcA and SrcB; signs are handled by magnitude conversion per MdOp.
  - BUSY: one radix-2 shift-add (mul) or restoring-subtract (div) step per cycle.
    - Counter decrements each step. At counter = 0, go to DONE.
  - DONE: the sign-corrected result is selected onto the ALU result. Go to IDLE next cycle.
- StallMdE = MdEnE & !FlushE & (state != DONE).
  - Combinational; high in the issue cycle and for all BUSY cycles.
- Latency: issue at cycle t. StallMdE is high t..t+N, low at t+N+1 (DONE). The result is captured into the M register at the end of t+N+1.
  - Total E occupancy = N+2 cycles.
- Result per MdOp:
  - 000 MUL: low half.
  - 001 MULH, 010 MULHSU, 011 MULHU: high half.
  - 100 DIV, 101 DIVU: quotient.
  - 110 REM, 111 REMU: remainder.
- Divide by zero: quotient = all ones; remainder = dividend (same latency).
- Signed overflow (MIN / -1): quotient = MIN; remainder = 0.
- While StallMdE = 1, the M register loads a bubble: RegWriteM = 0, MemWriteM = 0, RdM = 0, other fields don't-care. Upstream holds all E inputs stable.
- FlushE = 1, any state:
  - The FSM returns to IDLE next cycle and the M register loads a bubble.
  - A flush in BUSY discards the partial result.
- Reset mid-operation: the FSM goes to IDLE and the M register clears. Same as the reset values above.
- Non-MD instruction: single-cycle, never stalls.

Test Plan:
- ADD: RD1E=5, RD2E=7, ALUControl=0, ForwardAE=2 with ALUResultM=100 -> ALUResultM next cycle = 107; StallMdE stays 0.
- MUL, DATA_WIDTH=32: MdOp=000, RD1=0xFFFFFFFE, RD2=3 -> StallMdE high 33 cycles, then ALUResultM=0xFFFFFFFA. MULHU on the same operands -> 0x00000002.
- DIV: RD1=-7, RD2=2 -> quotient -3; REM -> -1. DIVU x/0 -> 0xFFFFFFFF; REM x/0 -> x. DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
- Branch: BLT with RD1=-1, RD2=1 -> PCSrcE=1, PCTargetE=PCE+Imm. JALR with RD1=0x101, Imm=4 -> PCTargetE=0x104.
- Flush: FlushE at the 10th BUSY cycle -> IDLE next cycle, StallMdE=0, RegWriteM=0. A subsequent MUL still returns the correct result.
- Reset mid-BUSY: rst high one cycle -> all outputs 0, StallMdE=0. Rerun with DATA_WIDTH=16 to check the latency scales to 18 cycles.

Source files
------------

// File: rtl/execute_stage_md.sv
// RV32IM execute stage: single-cycle ALU, iterative radix-2 multiply/divide unit,
// branch resolution and the E->M pipeline register.
module execute_stage_md #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteE,
  input  logic [1:0]            ResultSrcE,
  input  logic                  MemWriteE,
  input  logic [2:0]            MemoryOpE,
  input  logic [1:0]            JumpE,
  input  logic [2:0]            BranchE,
  input  logic                  BranchEnE,
  input  logic [3:0]            ALUControlE,
  input  logic                  ALUSrcE,
  input  logic [1:0]            UpperOpE,
  input  logic                  MdEnE,
  input  logic [2:0]            MdOpE,
  input  logic [DATA_WIDTH-1:0] RD1E,
  input  logic [DATA_WIDTH-1:0] RD2E,
  input  logic [DATA_WIDTH-1:0] PCE,
  input  logic [DATA_WIDTH-1:0] ImmExtE,
  input  logic [DATA_WIDTH-1:0] PCPlus4E,
  input  logic [ADDR_WIDTH-1:0] RdE,
  input  logic [1:0]            ForwardAE,
  input  logic [1:0]            ForwardBE,
  input  logic [DATA_WIDTH-1:0] ResultW,
  input  logic                  FlushE,
  output logic                  StallMdE,
  output logic                  RegWriteM,
  output logic [1:0]            ResultSrcM,
  output logic                  MemWriteM,
  output logic [2:0]            MemoryOpM,
  output logic [DATA_WIDTH-1:0] ALUResultM,
  output logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [ADDR_WIDTH-1:0] RdM,
  output logic [DATA_WIDTH-1:0] PCPlus4M,
  output logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  PCSrcE
);

  // state   | meaning
  // MD_IDLE | no M-extension op in flight; issue on MdEnE
  // MD_BUSY | one shift-add / restoring-subtract step per cycle
  // MD_DONE | sign-corrected result presented to the M register
  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

  localparam int N  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  logic [N-1:0] fwd_a, fwd_b, src_a, src_b, alu_result;
  logic [CW-1:0] shamt;
  logic          br_cond, jalr;
  logic [N-1:0]  target_sum;

  always_comb begin
    case (ForwardAE)
      2'd1:    fwd_a = ResultW;
      2'd2:    fwd_a = ALUResultM;
      default: fwd_a = RD1E;
    endcase
    case (ForwardBE)
      2'd1:    fwd_b = ResultW;
      2'd2:    fwd_b = ALUResultM;
      default: fwd_b = RD2E;
    endcase
    case (UpperOpE)
      2'd1:    src_a = '0;
      2'd2:    src_a = PCE;
      default: src_a = fwd_a;
    endcase
    src_b = ALUSrcE ? ImmExtE : fwd_b;
  end

  assign shamt = src_b[CW-1:0];

  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      4'd0: alu_result = src_a + src_b;
      4'd1: alu_result = src_a - src_b;
      4'd2: alu_result = src_a & src_b;
      4'd3: alu_result = src_a | src_b;
      4'd4: alu_result = src_a ^ src_b;
      4'd5: alu_result = src_a << shamt;
      4'd6: alu_result = src_a >> shamt;
      4'd7: alu_result = $signed(src_a) >>> shamt;
      4'd8: alu_result = {{(N-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      4'd9: alu_result = {{(N-1){1'b0}}, src_a < src_b};
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (BranchE)
      3'b000: br_cond = (fwd_a == fwd_b);
      3'b001: br_cond = (fwd_a != fwd_b);
      3'b100: br_cond = ($signed(fwd_a) <  $signed(fwd_b));
      3'b101: br_cond = ($signed(fwd_a) >= $signed(fwd_b));
      3'b110: br_cond = (fwd_a <  fwd_b);
      3'b111: br_cond = (fwd_a >= fwd_b);
      default: br_cond = 1'b0;
    endcase
  end

  assign jalr       = (JumpE == 2'b10);
  assign target_sum = (jalr ? fwd_a : PCE) + ImmExtE;
  assign PCTargetE  = {target_sum[N-1:1], target_sum[0] & ~jalr};
  assign PCSrcE     = ~FlushE & ((BranchEnE & br_cond) | (JumpE != 2'b00));

  // Operands are reduced to magnitudes at issue; signs are reapplied in DONE.
  logic         a_signed, b_signed, a_neg, b_neg;
  logic [N-1:0] a_mag, b_mag;

  assign a_signed = (MdOpE == 3'b001) | (MdOpE == 3'b010) | (MdOpE == 3'b100) | (MdOpE == 3'b110);
  assign b_signed = (MdOpE == 3'b001) | (MdOpE == 3'b100) | (MdOpE == 3'b110);
  assign a_neg    = a_signed & src_a[N-1];
  assign b_neg    = b_signed & src_b[N-1];
  assign a_mag    = a_neg ? -src_a : src_a;
  assign b_mag    = b_neg ? -src_b : src_b;

  md_state_t     md_state;
  logic [CW-1:0] md_cnt;
  logic [N-1:0]  md_hi, md_lo, md_b;
  logic [2:0]    md_op;
  logic          md_a_neg, md_b_neg, md_b_zero;

  logic [N:0]    mul_sum, div_shift;
  logic [N-1:0]  div_diff, md_hi_nxt, md_lo_nxt;
  logic          div_ge;

  // md_hi:md_lo is the product during MUL, remainder:dividend/quotient during DIV.
  assign mul_sum   = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_b} : '0);
  assign div_shift = {md_hi, md_lo[N-1]};
  assign div_ge    = (div_shift >= {1'b0, md_b});
  assign div_diff  = div_shift[N-1:0] - md_b;

  always_comb begin
    if (md_op[2]) begin
      md_hi_nxt = div_ge ? div_diff : div_shift[N-1:0];
      md_lo_nxt = {md_lo[N-2:0], div_ge};
    end else begin
      md_hi_nxt = mul_sum[N:1];
      md_lo_nxt = {mul_sum[0], md_lo[N-1:1]};
    end
  end

  logic [2*N-1:0] prod_s;
  logic [N-1:0]   quo_s, rem_s, md_result;

  assign prod_s = (md_a_neg ^ md_b_neg) ? -{md_hi, md_lo} : {md_hi, md_lo};
  // Divide by zero keeps the all-ones quotient regardless of dividend sign.
  assign quo_s  = ((md_a_neg ^ md_b_neg) & ~md_b_zero) ? -md_lo : md_lo;
  assign rem_s  = md_a_neg ? -md_hi : md_hi;

  always_comb begin
    case (md_op)
      3'b000:                 md_result = prod_s[N-1:0];
      3'b001, 3'b010, 3'b011: md_result = prod_s[2*N-1:N];
      3'b100, 3'b101:         md_result = quo_s;
      default:                md_result = rem_s;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      md_state  <= MD_IDLE;
      md_cnt    <= '0;
      md_hi     <= '0;
      md_lo     <= '0;
      md_b      <= '0;
      md_op     <= '0;
      md_a_neg  <= 1'b0;
      md_b_neg  <= 1'b0;
      md_b_zero <= 1'b0;
    end else if (FlushE) begin
      md_state <= MD_IDLE;
    end else begin
      case (md_state)
        MD_IDLE: if (MdEnE) begin
          md_state  <= MD_BUSY;
          md_cnt    <= CW'(N - 1);
          md_hi     <= '0;
          md_lo     <= a_mag;
          md_b      <= b_mag;
          md_op     <= MdOpE;
          md_a_neg  <= a_neg;
          md_b_neg  <= b_neg;
          md_b_zero <= (src_b == '0);
        end
        MD_BUSY: begin
          md_hi  <= md_hi_nxt;
          md_lo  <= md_lo_nxt;
          md_cnt <= md_cnt - 1'b1;
          if (md_cnt == '0) md_state <= MD_DONE;
        end
        MD_DONE: md_state <= MD_IDLE;
        default: md_state <= MD_IDLE;
      endcase
    end
  end

  logic md_done, load_bubble;

  assign md_done     = (md_state == MD_DONE);
  assign StallMdE    = MdEnE & ~FlushE & ~md_done;
  assign load_bubble = FlushE | StallMdE;

  always_ff @(posedge clk) begin
    if (rst || load_bubble) begin
      RegWriteM  <= 1'b0;
      ResultSrcM <= '0;
      MemWriteM  <= 1'b0;
      MemoryOpM  <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      RdM        <= '0;
      PCPlus4M   <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      ResultSrcM <= ResultSrcE;
      MemWriteM  <= MemWriteE;
      MemoryOpM  <= MemoryOpE;
      ALUResultM <= md_done ? md_result : alu_result;
      WriteDataM <= fwd_b;
      RdM        <= RdE;
      PCPlus4M   <= PCPlus4E;
    end
  end

endmodule
